// File: rtl/axi_wr_pkg.sv
// Shared definitions for the AXI4 write master and the MCTP generator/checker.
package axi_wr_pkg;

   // AXI burst types
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   // AXI response codes
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // MCTP transport header: packet position flags and sequence number
   localparam int unsigned MCTP_SOM_BIT    = 7;
   localparam int unsigned MCTP_EOM_BIT    = 6;
   localparam int unsigned MCTP_SEQ_LSB    = 4;
   localparam int unsigned MCTP_SEQ_W      = 2;
   localparam logic [1:0]  MCTP_POS_MIDDLE = 2'b00;
   localparam logic [1:0]  MCTP_POS_LAST   = 2'b01;
   localparam logic [1:0]  MCTP_POS_FIRST  = 2'b10;
   localparam logic [1:0]  MCTP_POS_ONLY   = 2'b11;

   // W channel sequencer states
   typedef enum logic {
      W_IDLE = 1'b0,
      W_DATA = 1'b1
   } w_state_e;

   // MCTP packet sequence numbers wrap modulo 4
   function automatic logic [MCTP_SEQ_W-1:0] mctp_seq_next(input logic [MCTP_SEQ_W-1:0] seq);
      return seq + MCTP_SEQ_W'(1);
   endfunction

endpackage

// File: rtl/axi_wr_cmd_fifo.sv
// Command-order FIFO linking accepted AW commands to their W bursts.
module axi_wr_cmd_fifo
   import axi_wr_pkg::*;
#(
   parameter int unsigned WIDTH = 137,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W:0]   wr_ptr_q;
   logic [PTR_W:0]   rd_ptr_q;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty
   assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

   // Pointer update; reset empties the FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      end
   end

   // Storage write
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
   end

endmodule

// File: rtl/axi_write_master.sv
// AXI4 write master: command port to AW, payload stream to W, B to completion/error reporting.
module axi_write_master
   import axi_wr_pkg::*;
#(
   parameter int unsigned DATA_W          = 256,
   parameter int unsigned ADDR_W          = 64,
   parameter int unsigned ID_W            = 7,
   parameter int unsigned HDR_W           = 128,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [ADDR_W-1:0]   i_cmd_addr,
   input  logic [7:0]          i_cmd_len,
   input  logic [2:0]          i_cmd_size,
   input  logic [1:0]          i_cmd_burst,
   input  logic [ID_W-1:0]     i_cmd_id,
   input  logic                i_cmd_hdr_en,
   input  logic [HDR_W-1:0]    i_cmd_hdr,
   input  logic                i_wd_valid,
   output logic                o_wd_ready,
   input  logic [DATA_W-1:0]   i_wd_data,
   input  logic [DATA_W/8-1:0] i_wd_strb,
   output logic [63:0]         O_AWUSER,
   output logic [ID_W-1:0]     O_AWID,
   output logic [ADDR_W-1:0]   O_AWADDR,
   output logic [7:0]          O_AWLEN,
   output logic [2:0]          O_AWSIZE,
   output logic [1:0]          O_AWBURST,
   output logic                O_AWLOCK,
   output logic [3:0]          O_AWCACHE,
   output logic [2:0]          O_AWPROT,
   output logic                O_AWVALID,
   input  logic                I_AWREADY,
   output logic [15:0]         O_WUSER,
   output logic [DATA_W-1:0]   O_WDATA,
   output logic [DATA_W/8-1:0] O_WSTRB,
   output logic                O_WLAST,
   output logic                O_WVALID,
   input  logic                I_WREADY,
   input  logic [ID_W-1:0]     I_BID,
   input  logic [1:0]          I_BRESP,
   input  logic                I_BVALID,
   output logic                O_BREADY,
   output logic                o_done,
   output logic [ID_W-1:0]     o_done_id,
   output logic [1:0]          o_done_resp,
   output logic                o_err,
   input  logic                i_err_clr,
   output logic                o_busy
);

   localparam int unsigned FIFO_W = 8 + 1 + HDR_W;
   localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

   // AW channel registers
   logic              awvalid_q;
   logic [ID_W-1:0]   awid_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic [7:0]        awlen_q;
   logic [2:0]        awsize_q;
   logic [1:0]        awburst_q;

   // W sequencer registers
   w_state_e          state_q;
   logic [7:0]        beat_cnt_q;
   logic              first_q;
   logic              hdr_en_q;
   logic [HDR_W-1:0]  hdr_q;

   // Completion/status registers
   logic [OUT_W-1:0]  outst_q;
   logic [OUT_W-1:0]  outst_d;
   logic              done_q;
   logic [ID_W-1:0]   done_id_q;
   logic [1:0]        done_resp_q;
   logic              err_q;

   logic              fifo_full;
   logic              fifo_empty;
   logic              fifo_pop;
   logic [FIFO_W-1:0] fifo_wdata;
   logic [FIFO_W-1:0] fifo_rdata;
   logic              cmd_fire;
   logic              b_fire;
   logic              b_dec;
   logic              err_set;
   logic              w_active;
   logic              w_fire;
   logic [DATA_W-1:0] w_data;

   assign o_cmd_ready = !i_reset && !awvalid_q && (outst_q < OUT_MAX) && !fifo_full;
   assign cmd_fire    = i_cmd_valid && o_cmd_ready;
   assign fifo_wdata  = {i_cmd_len, i_cmd_hdr_en, i_cmd_hdr};
   assign fifo_pop    = (state_q == W_IDLE) && !fifo_empty;

   axi_wr_cmd_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_cmd_fifo (
      .clk_i   (i_clk),
      .rst_i   (i_reset),
      .push_i  (cmd_fire),
      .data_i  (fifo_wdata),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // AW: capture command fields on accept, hold until the slave takes them
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         awvalid_q <= 1'b0;
         awid_q    <= '0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         awsize_q  <= '0;
         awburst_q <= '0;
      end else if (cmd_fire) begin
         awvalid_q <= 1'b1;
         awid_q    <= i_cmd_id;
         awaddr_q  <= i_cmd_addr;
         awlen_q   <= i_cmd_len;
         awsize_q  <= i_cmd_size;
         awburst_q <= i_cmd_burst;
      end else if (awvalid_q && I_AWREADY) begin
         awvalid_q <= 1'b0;
      end
   end

   assign O_AWVALID = awvalid_q;
   assign O_AWID    = awid_q;
   assign O_AWADDR  = awaddr_q;
   assign O_AWLEN   = awlen_q;
   assign O_AWSIZE  = awsize_q;
   assign O_AWBURST = awburst_q;
   assign O_AWUSER  = '0;
   assign O_AWLOCK  = 1'b0;
   assign O_AWCACHE = '0;
   assign O_AWPROT  = '0;
   assign O_WUSER   = '0;

   // W sequencer: take the next burst from the FIFO, count beats down to WLAST
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= W_IDLE;
         beat_cnt_q <= '0;
         first_q    <= 1'b0;
         hdr_en_q   <= 1'b0;
         hdr_q      <= '0;
      end else begin
         case (state_q)
            W_IDLE: begin
               if (!fifo_empty) begin
                  state_q    <= W_DATA;
                  beat_cnt_q <= fifo_rdata[FIFO_W-1 -: 8];
                  hdr_en_q   <= fifo_rdata[HDR_W];
                  hdr_q      <= fifo_rdata[HDR_W-1:0];
                  first_q    <= 1'b1;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  first_q    <= 1'b0;
                  beat_cnt_q <= beat_cnt_q - 8'd1;
                  if (beat_cnt_q == 8'd0) state_q <= W_IDLE;
               end
            end
            default: state_q <= W_IDLE;
         endcase
      end
   end

   // Beat 0 of a header-enabled burst carries the TLP header in its low bits
   always_comb begin
      w_data = i_wd_data;
      if (first_q && hdr_en_q) w_data[HDR_W-1:0] = hdr_q;
   end

   assign w_active   = (state_q == W_DATA);
   assign w_fire     = w_active && i_wd_valid && I_WREADY;
   assign O_WVALID   = w_active && i_wd_valid;
   assign o_wd_ready = w_active && I_WREADY;
   assign O_WDATA    = w_active ? w_data : '0;
   assign O_WSTRB    = w_active ? i_wd_strb : '0;
   assign O_WLAST    = w_active && (beat_cnt_q == 8'd0);

   assign O_BREADY = !i_reset;
   assign b_fire   = I_BVALID && O_BREADY;
   assign b_dec    = b_fire && (outst_q != '0);
   assign err_set  = b_fire && ((I_BRESP != RESP_OKAY) || (outst_q == '0));

   // Outstanding count: an unexpected B leaves it untouched
   always_comb begin
      outst_d = outst_q;
      if (cmd_fire && !b_dec)      outst_d = outst_q + OUT_W'(1);
      else if (!cmd_fire && b_dec) outst_d = outst_q - OUT_W'(1);
   end

   // Completion pulse, response capture, sticky error and outstanding count
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         outst_q     <= '0;
         done_q      <= 1'b0;
         done_id_q   <= '0;
         done_resp_q <= '0;
         err_q       <= 1'b0;
      end else begin
         outst_q <= outst_d;
         done_q  <= b_fire;
         if (b_fire) begin
            done_id_q   <= I_BID;
            done_resp_q <= I_BRESP;
         end
         if (err_set)        err_q <= 1'b1;
         else if (i_err_clr) err_q <= 1'b0;
      end
   end

   assign o_done      = done_q;
   assign o_done_id   = done_id_q;
   assign o_done_resp = done_resp_q;
   assign o_err       = err_q;
   assign o_busy      = awvalid_q || w_active || (outst_q != '0);

endmodule

// File: tb/tb_axi_write_master.sv
// Directed self-checking bench for axi_write_master.
module tb_axi_write_master;
   import axi_wr_pkg::*;

   localparam int unsigned DATA_W  = 256;
   localparam int unsigned ADDR_W  = 64;
   localparam int unsigned ID_W    = 7;
   localparam int unsigned HDR_W   = 128;
   localparam int unsigned MAX_OUT = 4;

   localparam logic [HDR_W-1:0] HDR1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_7FA0;
   localparam logic [HDR_W-1:0] HDR2 = 128'hAAAA_5555_1234_5678_9ABC_DEF0_0F0F_7FA1;

   logic                i_clk = 1'b0;
   logic                i_reset;
   logic                i_cmd_valid;
   logic                o_cmd_ready;
   logic [ADDR_W-1:0]   i_cmd_addr;
   logic [7:0]          i_cmd_len;
   logic [2:0]          i_cmd_size;
   logic [1:0]          i_cmd_burst;
   logic [ID_W-1:0]     i_cmd_id;
   logic                i_cmd_hdr_en;
   logic [HDR_W-1:0]    i_cmd_hdr;
   logic                i_wd_valid;
   logic                o_wd_ready;
   logic [DATA_W-1:0]   i_wd_data;
   logic [DATA_W/8-1:0] i_wd_strb;
   logic [63:0]         O_AWUSER;
   logic [ID_W-1:0]     O_AWID;
   logic [ADDR_W-1:0]   O_AWADDR;
   logic [7:0]          O_AWLEN;
   logic [2:0]          O_AWSIZE;
   logic [1:0]          O_AWBURST;
   logic                O_AWLOCK;
   logic [3:0]          O_AWCACHE;
   logic [2:0]          O_AWPROT;
   logic                O_AWVALID;
   logic                I_AWREADY;
   logic [15:0]         O_WUSER;
   logic [DATA_W-1:0]   O_WDATA;
   logic [DATA_W/8-1:0] O_WSTRB;
   logic                O_WLAST;
   logic                O_WVALID;
   logic                I_WREADY;
   logic [ID_W-1:0]     I_BID;
   logic [1:0]          I_BRESP;
   logic                I_BVALID;
   logic                O_BREADY;
   logic                o_done;
   logic [ID_W-1:0]     o_done_id;
   logic [1:0]          o_done_resp;
   logic                o_err;
   logic                i_err_clr;
   logic                o_busy;

   axi_write_master #(
      .DATA_W          (DATA_W),
      .ADDR_W          (ADDR_W),
      .ID_W            (ID_W),
      .HDR_W           (HDR_W),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_cmd_valid  (i_cmd_valid),
      .o_cmd_ready  (o_cmd_ready),
      .i_cmd_addr   (i_cmd_addr),
      .i_cmd_len    (i_cmd_len),
      .i_cmd_size   (i_cmd_size),
      .i_cmd_burst  (i_cmd_burst),
      .i_cmd_id     (i_cmd_id),
      .i_cmd_hdr_en (i_cmd_hdr_en),
      .i_cmd_hdr    (i_cmd_hdr),
      .i_wd_valid   (i_wd_valid),
      .o_wd_ready   (o_wd_ready),
      .i_wd_data    (i_wd_data),
      .i_wd_strb    (i_wd_strb),
      .O_AWUSER     (O_AWUSER),
      .O_AWID       (O_AWID),
      .O_AWADDR     (O_AWADDR),
      .O_AWLEN      (O_AWLEN),
      .O_AWSIZE     (O_AWSIZE),
      .O_AWBURST    (O_AWBURST),
      .O_AWLOCK     (O_AWLOCK),
      .O_AWCACHE    (O_AWCACHE),
      .O_AWPROT     (O_AWPROT),
      .O_AWVALID    (O_AWVALID),
      .I_AWREADY    (I_AWREADY),
      .O_WUSER      (O_WUSER),
      .O_WDATA      (O_WDATA),
      .O_WSTRB      (O_WSTRB),
      .O_WLAST      (O_WLAST),
      .O_WVALID     (O_WVALID),
      .I_WREADY     (I_WREADY),
      .I_BID        (I_BID),
      .I_BRESP      (I_BRESP),
      .I_BVALID     (I_BVALID),
      .O_BREADY     (O_BREADY),
      .o_done       (o_done),
      .o_done_id    (o_done_id),
      .o_done_resp  (o_done_resp),
      .o_err        (o_err),
      .i_err_clr    (i_err_clr),
      .o_busy       (o_busy)
   );

   // 100 MHz clock
   always #5 i_clk = ~i_clk;

   int unsigned n_assert = 0;
   int unsigned n_fail   = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_assert++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor state (written only by the monitor process)
   logic [DATA_W-1:0]   wd_q [$];
   logic [DATA_W/8-1:0] ws_q [$];
   logic                wl_q [$];
   int unsigned aw_stall = 0, aw_viol = 0, w_stall = 0, w_viol = 0, done_cnt = 0;
   logic        aw_hold = 1'b0, w_hold = 1'b0;
   logic [ADDR_W+ID_W+8+3+2-1:0]   aw_snap;
   logic [DATA_W+DATA_W/8+1-1:0]   w_snap;

   // Record W handshakes, count completions and check AW/W stability under backpressure
   always @(negedge i_clk) begin
      if (O_WVALID && I_WREADY) begin
         wd_q.push_back(O_WDATA);
         ws_q.push_back(O_WSTRB);
         wl_q.push_back(O_WLAST);
      end
      if (o_done) done_cnt++;
      if (aw_hold && (!O_AWVALID || {O_AWADDR, O_AWID, O_AWLEN, O_AWSIZE, O_AWBURST} !== aw_snap))
         aw_viol++;
      if (w_hold && (!O_WVALID || {O_WDATA, O_WSTRB, O_WLAST} !== w_snap))
         w_viol++;
      aw_hold = O_AWVALID && !I_AWREADY;
      w_hold  = O_WVALID && !I_WREADY;
      if (aw_hold) aw_stall++;
      if (w_hold)  w_stall++;
      aw_snap = {O_AWADDR, O_AWID, O_AWLEN, O_AWSIZE, O_AWBURST};
      w_snap  = {O_WDATA, O_WSTRB, O_WLAST};
   end

   function automatic logic [DATA_W-1:0] pay(input int unsigned k);
      logic [31:0] w;
      w = 32'hC0DE_0000 + k;
      return {8{w}};
   endfunction

   function automatic logic [DATA_W/8-1:0] stb(input int unsigned k);
      logic [31:0] s;
      s = 32'hF0F0_0000 | k;
      return s;
   endfunction

   task automatic tick;
      @(posedge i_clk);
      #1;
   endtask

   task automatic issue_cmd(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                            input logic [ID_W-1:0] id, input logic he, input logic [HDR_W-1:0] h);
      int unsigned t;
      logic acc;
      t = 0;
      acc = 1'b0;
      i_cmd_addr   = a;
      i_cmd_len    = l;
      i_cmd_id     = id;
      i_cmd_hdr_en = he;
      i_cmd_hdr    = h;
      i_cmd_size   = 3'd5;
      i_cmd_burst  = BURST_INCR;
      i_cmd_valid  = 1'b1;
      while (!acc && t < 50) begin
         @(negedge i_clk);
         acc = o_cmd_ready;
         tick();
         t++;
      end
      i_cmd_valid = 1'b0;
      if (!acc) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic send_beat(input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] s, input logic gap);
      int unsigned t;
      logic fired;
      t = 0;
      fired = 1'b0;
      if (gap) begin
         i_wd_valid = 1'b0;
         tick();
      end
      i_wd_valid = 1'b1;
      i_wd_data  = d;
      i_wd_strb  = s;
      while (!fired && t < 200) begin
         @(negedge i_clk);
         fired = o_wd_ready;
         tick();
         t++;
      end
      i_wd_valid = 1'b0;
      if (!fired) chk("wd_beat_timeout", 0, 1);
   endtask

   task automatic send_b(input logic [ID_W-1:0] id, input logic [1:0] r, input logic clr);
      I_BVALID  = 1'b1;
      I_BID     = id;
      I_BRESP   = r;
      i_err_clr = clr;
      tick();
      I_BVALID  = 1'b0;
      i_err_clr = 1'b0;
   endtask

   // Hang guard
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   int unsigned base, nb, s0, v0, ws0, wv0, d0;
   logic [DATA_W-1:0] exp_d;
   logic stop;

   // Directed sequence
   initial begin
      i_reset = 1'b1;
      i_cmd_valid = 1'b0; i_cmd_addr = '0; i_cmd_len = '0; i_cmd_size = '0;
      i_cmd_burst = '0; i_cmd_id = '0; i_cmd_hdr_en = 1'b0; i_cmd_hdr = '0;
      i_wd_valid = 1'b0; i_wd_data = '0; i_wd_strb = '0;
      I_AWREADY = 1'b1; I_WREADY = 1'b1;
      I_BVALID = 1'b0; I_BID = '0; I_BRESP = '0; i_err_clr = 1'b0;
      stop = 1'b0;
      repeat (3) tick();

      chk("rst_awvalid", O_AWVALID, 0);
      chk("rst_wvalid", O_WVALID, 0);
      chk("rst_bready", O_BREADY, 0);
      chk("rst_cmd_ready", o_cmd_ready, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_err", o_err, 0);
      i_reset = 1'b0;
      tick();
      chk("bready_up", O_BREADY, 1);
      chk("idle_cmd_ready", o_cmd_ready, 1);

      // Single command with header insertion
      base = wd_q.size();
      chk("t1_aw_pre", O_AWVALID, 0);
      issue_cmd(64'h0, 8'd3, 7'd5, 1'b1, HDR1);
      chk("t1_awvalid", O_AWVALID, 1);
      chk("t1_awaddr", O_AWADDR, 64'h0);
      chk("t1_awlen", O_AWLEN, 3);
      chk("t1_awid", O_AWID, 5);
      chk("t1_awsize", O_AWSIZE, 5);
      chk("t1_awburst", O_AWBURST, BURST_INCR);
      chk("t1_awuser", O_AWUSER, 0);
      chk("t1_wuser", O_WUSER, 0);
      for (int k = 0; k < 4; k++) send_beat(pay(k), stb(k), 1'b0);
      repeat (2) tick();
      nb = wd_q.size() - base;
      chk("t1_nbeats", nb, 4);
      for (int k = 0; k < 4 && k < int'(nb); k++) begin
         exp_d = pay(k);
         if (k == 0) exp_d[HDR_W-1:0] = HDR1;
         chk($sformatf("t1_data%0d", k), wd_q[base+k], exp_d);
         chk($sformatf("t1_strb%0d", k), ws_q[base+k], stb(k));
         chk($sformatf("t1_last%0d", k), wl_q[base+k], (k == 3) ? 1 : 0);
      end
      send_b(7'd5, RESP_OKAY, 1'b0);
      chk("t1_done", o_done, 1);
      chk("t1_done_id", o_done_id, 5);
      chk("t1_done_resp", o_done_resp, 0);
      chk("t1_err", o_err, 0);
      tick();
      chk("t1_done_pulse", o_done, 0);
      chk("t1_busy", o_busy, 0);

      // Backpressure on AW and W, gaps on the payload stream
      base = wd_q.size(); s0 = aw_stall; v0 = aw_viol; ws0 = w_stall; wv0 = w_viol;
      I_AWREADY = 1'b0;
      issue_cmd(64'h1000, 8'd3, 7'd3, 1'b0, HDR2);
      stop = 1'b0;
      fork
         begin
            repeat (5) @(posedge i_clk);
            #1 I_AWREADY = 1'b1;
         end
         begin
            for (int k = 0; k < 4; k++) send_beat(pay(10 + k), stb(10 + k), (k % 2) == 1);
            stop = 1'b1;
         end
         begin
            for (int t = 0; t < 400 && !stop; t++) begin
               @(posedge i_clk);
               #1 I_WREADY = !I_WREADY;
            end
         end
      join
      I_WREADY = 1'b1;
      repeat (2) tick();
      nb = wd_q.size() - base;
      chk("t2_nbeats", nb, 4);
      for (int k = 0; k < 4 && k < int'(nb); k++) begin
         chk($sformatf("t2_data%0d", k), wd_q[base+k], pay(10 + k));
         chk($sformatf("t2_last%0d", k), wl_q[base+k], (k == 3) ? 1 : 0);
      end
      chk("t2_aw_stall", aw_stall - s0, 5);
      chk("t2_aw_stable", aw_viol - v0, 0);
      chk("t2_w_stalled", (w_stall - ws0) != 0, 1);
      chk("t2_w_stable", w_viol - wv0, 0);
      send_b(7'd3, RESP_OKAY, 1'b0);
      chk("t2_done_id", o_done_id, 3);
      tick();

      // Outstanding limit
      base = wd_q.size();
      for (int i = 0; i < 4; i++) issue_cmd(64'h2000 + 64'(i * 256), 8'd0, 7'(i + 1), 1'b0, '0);
      i_cmd_addr = 64'h2400; i_cmd_id = 7'd5; i_cmd_valid = 1'b1;
      repeat (2) tick();
      chk("t3_ready_full", o_cmd_ready, 0);
      chk("t3_busy", o_busy, 1);
      send_b(7'd1, RESP_OKAY, 1'b0);
      chk("t3_ready_back", o_cmd_ready, 1);
      tick();
      i_cmd_valid = 1'b0;
      chk("t3_aw5_valid", O_AWVALID, 1);
      chk("t3_aw5_id", O_AWID, 5);
      for (int k = 0; k < 5; k++) send_beat(pay(40 + k), stb(40 + k), 1'b0);
      repeat (2) tick();
      nb = wd_q.size() - base;
      chk("t3_nbeats", nb, 5);
      for (int k = 0; k < 5 && k < int'(nb); k++)
         chk($sformatf("t3_last%0d", k), wl_q[base+k], 1);

      // Error response on the second burst
      send_b(7'd2, RESP_SLVERR, 1'b0);
      chk("t4_done_resp", o_done_resp, 2);
      chk("t4_done_id", o_done_id, 2);
      chk("t4_err", o_err, 1);
      send_b(7'd3, RESP_OKAY, 1'b0);
      send_b(7'd4, RESP_OKAY, 1'b0);
      send_b(7'd5, RESP_OKAY, 1'b0);
      tick();
      chk("t4_err_sticky", o_err, 1);
      chk("t4_idle", o_busy, 0);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("t4_err_clr", o_err, 0);

      // Unexpected B with nothing outstanding
      send_b(7'd9, RESP_OKAY, 1'b0);
      chk("t5_done", o_done, 1);
      chk("t5_err", o_err, 1);
      tick();
      chk("t5_busy", o_busy, 0);
      chk("t5_cmd_ready", o_cmd_ready, 1);
      i_err_clr = 1'b1;
      tick();
      i_err_clr = 1'b0;
      chk("t5_err_clr", o_err, 0);
      send_b(7'd1, RESP_DECERR, 1'b1);
      chk("t5_set_wins", o_err, 1);
      chk("t5_done_resp", o_done_resp, 3);
      tick();

      // Reset in the middle of a burst
      issue_cmd(64'h3000, 8'd3, 7'h11, 1'b1, HDR2);
      send_beat(pay(20), stb(20), 1'b0);
      send_beat(pay(21), stb(21), 1'b0);
      d0 = done_cnt;
      i_reset = 1'b1;
      tick();
      chk("t6_awvalid", O_AWVALID, 0);
      chk("t6_awaddr", O_AWADDR, 0);
      chk("t6_wvalid", O_WVALID, 0);
      chk("t6_wlast", O_WLAST, 0);
      chk("t6_wdata", O_WDATA, 0);
      chk("t6_wd_ready", o_wd_ready, 0);
      chk("t6_cmd_ready", o_cmd_ready, 0);
      chk("t6_bready", O_BREADY, 0);
      chk("t6_done", o_done, 0);
      chk("t6_err", o_err, 0);
      chk("t6_busy", o_busy, 0);
      i_reset = 1'b0;
      repeat (3) tick();
      chk("t6_no_done", done_cnt - d0, 0);
      chk("t6_idle", o_busy, 0);
      base = wd_q.size();
      issue_cmd(64'h4000, 8'd3, 7'h22, 1'b0, HDR2);
      for (int k = 0; k < 4; k++) send_beat(pay(30 + k), stb(30 + k), 1'b0);
      repeat (2) tick();
      nb = wd_q.size() - base;
      chk("t6_nbeats", nb, 4);
      for (int k = 0; k < 4 && k < int'(nb); k++) begin
         chk($sformatf("t6_data%0d", k), wd_q[base+k], pay(30 + k));
         chk($sformatf("t6_last%0d", k), wl_q[base+k], (k == 3) ? 1 : 0);
      end
      send_b(7'h22, RESP_OKAY, 1'b0);
      chk("t6_done", o_done, 1);
      chk("t6_done_id", o_done_id, 7'h22);
      chk("t6_err_after", o_err, 0);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_write_master.md
# axi_write_master

Synthesizable, parametrised AXI4 write master replacing the simulation-only write generator in the PCIe-VDM/MCTP datapath. Accepts write commands (address, length, optional 128-bit TLP header) on a valid/ready port and payload beats on a stream port. Drives AW, W and B independently, with up to MAX_OUTSTANDING bursts in flight. Reports each completion and any error response to the control plane.

## Interface
- DATA_W, 256: W data width, bits; multiple of 8, ≥ HDR_W
- ADDR_W, 64: address width
- ID_W, 7: AXI ID width
- HDR_W, 128: header width inserted into beat 0
- MAX_OUTSTANDING, 4: max accepted-but-unresponded bursts; power of 2, ≥2
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_cmd_valid / o_cmd_ready  in/out  1  command handshake
- i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_burst, i_cmd_id  in  ADDR_W/8/3/2/ID_W  AW fields
- i_cmd_hdr_en  in  1  replace beat-0 bits [HDR_W-1:0] with i_cmd_hdr
- i_cmd_hdr  in  HDR_W  TLP header
- i_wd_valid / o_wd_ready  in/out  1  payload stream handshake
- i_wd_data, i_wd_strb  in  DATA_W, DATA_W/8  payload beat
- O_AW* (USER 64, ID, ADDR, LEN, SIZE, BURST, LOCK, CACHE 4, PROT 3, VALID), I_AWREADY: AXI write address
- O_WUSER 16, O_WDATA, O_WSTRB, O_WLAST, O_WVALID, I_WREADY: AXI write data
- I_BID, I_BRESP 2, I_BVALID, O_BREADY: AXI write response
- o_done  out  1  one-cycle pulse per B handshake
- o_done_id, o_done_resp  out  ID_W, 2  ID/resp of that response
- o_err  out  1  sticky: non-OKAY resp or unexpected B
- i_err_clr  in  1  clears o_err
- o_busy  out  1  any AW pending, W burst active or outstanding ≠ 0

## Operation
- o_cmd_ready = !O_AWVALID && outstanding < MAX_OUTSTANDING && !len_fifo_full.
- Command accept: register AW fields, O_AWVALID←1; push {len, hdr_en, hdr} into len FIFO; outstanding+1.
- O_AWUSER, O_AWLOCK, O_AWCACHE, O_AWPROT, O_WUSER constant 0.
- AW held stable until I_AWREADY; O_AWVALID←0 on handshake.
- W FSM W_IDLE: FIFO non-empty → pop, beat_cnt←len, first←1, latch hdr → W_DATA.
- W FSM W_DATA: O_WVALID = i_wd_valid; o_wd_ready = I_WREADY. Both combinational, gated by state.
- O_WDATA = first && hdr_en ? {i_wd_data[DATA_W-1:HDR_W], hdr} : i_wd_data. O_WSTRB = i_wd_strb.
- O_WLAST = (beat_cnt == 0).
- Per W handshake: first←0, beat_cnt−1. On last beat handshake → W_IDLE.
- W may lead, coincide with or trail its AW. Bursts are issued in command order.
- O_BREADY = 1 whenever not in reset.
- B handshake: o_done pulse next cycle with registered I_BID/I_BRESP; outstanding−1.
- I_BRESP ≠ 2'b00 sets o_err.
- B with outstanding == 0: counter holds at 0, o_err set, o_done still pulses.
- Same-cycle cmd accept and B: outstanding unchanged.
- i_err_clr concurrent with a set event: set wins.

## Timing
- Reset: every O_*/o_* output 0, including O_BREADY. FIFO emptied, W FSM → W_IDLE, outstanding 0.
- Reset mid-burst abandons all transactions. No completion is reported.
- Cmd accept at edge N → O_AWVALID high from N+1.
- FIFO push at N → W FSM leaves W_IDLE at N+1 → O_WVALID can be high from N+2.
- Back-to-back bursts: one W_IDLE bubble cycle between WLAST and the next beat 0.
- Full throughput: one beat per cycle while i_wd_valid && I_WREADY.
- B accepted at N → o_done high during N+1 only.
- o_busy is a combinational OR of registered state.

## Structure
- Package axi_wr_pkg holds:
  - BURST_FIXED/INCR/WRAP
  - RESP_OKAY/EXOKAY/SLVERR/DECERR
  - the MCTP packet-position and sequence-number localparams shared with the generator/checker
- Sub-module axi_wr_cmd_fifo: synchronous FIFO, width 8+1+HDR_W, depth MAX_OUTSTANDING, full/empty flags, same reset.

## Test plan
- Single command: addr 0x0, len 3, hdr_en 1, hdr 128'h…7F_A0, four payloads, AWREADY/WREADY held 1, BRESP 0. Expect:
  - AW one cycle after accept
  - beat 0 low 128 bits = hdr
  - WLAST on beat 3
  - o_done one cycle after B, o_err 0
- Backpressure: AWREADY low 5 cycles, WREADY toggling, i_wd_valid gaps. Expect AW/W fields stable while valid && !ready, and exactly 4 beats.
- Outstanding limit: MAX_OUTSTANDING=4, issue 5 commands, no B. Expect o_cmd_ready 0 after the 4th. One B restores ready next cycle.
- Error: BRESP=2'b10 on 2nd burst. Expect o_err=1, o_done_resp=2. o_err held until i_err_clr, then 0.
- Unexpected B with outstanding 0. Expect o_err=1 and the counter stays 0.
- Reset mid-burst (after beat 1 of 4). Expect all outputs 0 next cycle. A fresh command then completes normally with hdr_en 0 (beat 0 unmodified).
